// File: rtl/bistable_ring_ctrl.sv
// bistable_ring_ctrl
//   Sequencer for a 32-stage bistable ring PUF. For each accepted challenge it
//   runs N evaluations of the ring. Each evaluation holds the ring in reset
//   for R cycles, releases it for S cycles, and then samples the synchronized
//   response. Once all evaluations are done it returns the majority-voted bit,
//   a stability flag and the count of ones over a valid/ready handshake.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   req_valid/req_ready   challenge request handshake
//   req_challenge         challenge to evaluate (latched on acceptance)
//   cfg_reset_cycles      ring reset hold length R (0 behaves as 1)
//   cfg_settle_cycles     ring settle length S (0 behaves as 1)
//   cfg_samples           evaluations per request N (0 behaves as 1)
//   rsp_valid/rsp_ready   result handshake
//   rsp_bit               majority vote (a tie yields 0)
//   rsp_stable            all samples agreed
//   rsp_ones              number of samples that read 1
//   ring_challenge        drives the ring challenge inputs
//   ring_reset            drives the ring reset, active-high
//   ring_response         asynchronous ring output
module bistable_ring_ctrl #(
    parameter int CHAL_W = 32,
    parameter int RST_W  = 8,
    parameter int SET_W  = 16,
    parameter int SMP_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] req_challenge,
    input  logic [RST_W-1:0]  cfg_reset_cycles,
    input  logic [SET_W-1:0]  cfg_settle_cycles,
    input  logic [SMP_W-1:0]  cfg_samples,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic              rsp_stable,
    output logic [SMP_W-1:0]  rsp_ones,
    output logic [CHAL_W-1:0] ring_challenge,
    output logic              ring_reset,
    input  logic              ring_response
);

    // One phase counter serves both HOLD and SETTLE, so it is sized for the wider of the two.
    localparam int CNT_W = (RST_W > SET_W) ? RST_W : SET_W;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SETTLE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [RST_W-1:0]   r_len;
    logic [SET_W-1:0]   s_len;
    logic [SMP_W-1:0]   n_len;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   r_last;
    logic [CNT_W-1:0]   s_last;
    logic [SMP_W:0]     ones_cnt;
    logic [SMP_W:0]     smp_cnt;
    logic [SMP_W:0]     ones_next;
    logic [SMP_W:0]     smp_next;
    logic [SMP_W+1:0]   twice_ones;
    logic               sync_meta;
    logic               sync_resp;
    logic               hold_done;
    logic               settle_done;
    logic               last_sample;

    assign r_last      = CNT_W'(r_len) - CNT_W'(1);
    assign s_last      = CNT_W'(s_len) - CNT_W'(1);
    assign hold_done   = (phase_cnt == r_last);
    assign settle_done = (phase_cnt == s_last);

    // The sample taken at the end of SETTLE is folded in here, so the results
    // can be registered on the same edge that enters DONE.
    assign ones_next   = ones_cnt + (SMP_W+1)'(sync_resp);
    assign smp_next    = smp_cnt + (SMP_W+1)'(1);
    assign last_sample = (smp_next == (SMP_W+1)'(n_len));
    assign twice_ones  = {ones_next, 1'b0};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control outputs. The ring is released only in SETTLE.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        ring_reset = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                ring_reset = 1'b0;
                if (settle_done) begin
                    state_next = last_sample ? DONE : HOLD;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: synchronizer, latched request, phase and sample counters, and results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta      <= 1'b0;
            sync_resp      <= 1'b0;
            ring_challenge <= '0;
            r_len          <= '0;
            s_len          <= '0;
            n_len          <= '0;
            phase_cnt      <= '0;
            ones_cnt       <= '0;
            smp_cnt        <= '0;
            rsp_bit        <= 1'b0;
            rsp_stable     <= 1'b0;
            rsp_ones       <= '0;
        end else begin
            sync_meta <= ring_response;
            sync_resp <= sync_meta;
            case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    if (req_valid) begin
                        ring_challenge <= req_challenge;
                        r_len    <= (cfg_reset_cycles  == '0) ? RST_W'(1) : cfg_reset_cycles;
                        s_len    <= (cfg_settle_cycles == '0) ? SET_W'(1) : cfg_settle_cycles;
                        n_len    <= (cfg_samples       == '0) ? SMP_W'(1) : cfg_samples;
                        ones_cnt <= '0;
                        smp_cnt  <= '0;
                    end
                end
                HOLD: begin
                    phase_cnt <= hold_done ? '0 : phase_cnt + CNT_W'(1);
                end
                SETTLE: begin
                    if (settle_done) begin
                        phase_cnt <= '0;
                        ones_cnt  <= ones_next;
                        smp_cnt   <= smp_next;
                        if (last_sample) begin
                            rsp_ones   <= ones_next[SMP_W-1:0];
                            rsp_bit    <= (twice_ones > (SMP_W+2)'(n_len));
                            rsp_stable <= (ones_next == '0) ||
                                          (ones_next == (SMP_W+1)'(n_len));
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bistable_ring_ctrl.md
Name: bistable_ring_ctrl

Overview:
- Sequencer for the 32-stage bistable ring PUF; drives the ring's `challenge` and `reset` inputs and samples its asynchronous `response`.
- Accepts one challenge per request and runs N reset/settle/sample evaluations of the ring.
- Returns the majority-voted bit plus a stability flag over a valid/ready handshake.
- Sits between the PUF host interface (key generation, enrollment) and the ring instance.

Parameters:
- CHAL_W, 32, challenge width; must match ring stage count.
- RST_W, 8, width of cfg_reset_cycles.
- SET_W, 16, width of cfg_settle_cycles.
- SMP_W, 4, width of cfg_samples.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  challenge request valid.
- req_ready  out  1  controller can accept a request.
- req_challenge  in  CHAL_W  challenge to evaluate.
- cfg_reset_cycles  in  RST_W  ring-reset hold length per evaluation; 0 is treated as 1.
- cfg_settle_cycles  in  SET_W  settle length per evaluation; 0 is treated as 1.
- cfg_samples  in  SMP_W  evaluations per request; 0 is treated as 1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  host accepts result.
- rsp_bit  out  1  majority-voted response.
- rsp_stable  out  1  all samples agreed.
- rsp_ones  out  SMP_W  count of samples equal to 1.
- ring_challenge  out  CHAL_W  to ring `challenge`.
- ring_reset  out  1  to ring `reset`, active-high.
- ring_response  in  1  from ring `response`; asynchronous.

Behaviour:
- Reset values (applied immediately while reset_n=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_bit=0, rsp_stable=0, rsp_ones=0.
  - ring_challenge=0, ring_reset=1, synchronizer flops=0, all counters=0.
- Synchronizer: ring_response passes through 2 flops, giving sync_resp. Only sync_resp is used. Settle time must cover the 2-cycle synchronizer latency; this is the user's responsibility.
- States:
  - IDLE: req_ready=1, ring_reset=1. On req_valid&req_ready:
    - latch req_challenge into ring_challenge;
    - latch R=max(cfg_reset_cycles,1), S=max(cfg_settle_cycles,1), N=max(cfg_samples,1);
    - clear ones_cnt and smp_cnt;
    - go to HOLD.
  - HOLD: ring_reset=1 for exactly R cycles, then go to SETTLE.
  - SETTLE: ring_reset=0 for exactly S cycles. On the clock edge ending the S-th cycle:
    - sample sync_resp; ones_cnt += sync_resp; smp_cnt += 1;
    - if smp_cnt (after increment) == N, go to DONE, else go to HOLD.
  - DONE: ring_reset=1, rsp_valid=1, outputs held stable. On rsp_valid&rsp_ready, go to IDLE; rsp_valid falls the next cycle.
- Config ports, req_challenge and req_valid are ignored outside IDLE. Latched values are held constant for the whole request.
- ring_challenge changes only on request acceptance, never while ring_reset=0. It holds its last value in IDLE/DONE.
- Latency: with acceptance at edge 0, rsp_valid is first observed high after edge N*(R+S).
- Results, registered on entry to DONE:
  - rsp_ones = ones_cnt.
  - rsp_bit = (2*ones_cnt > N). A tie with even N yields 0.
  - rsp_stable = (ones_cnt==0) || (ones_cnt==N).
- Arithmetic:
  - ones_cnt and smp_cnt are SMP_W+1 bits internally; no overflow for N ≤ 2^SMP_W−1.
  - The 2*ones_cnt comparison uses SMP_W+2 bits.
- Back-to-back: req_ready is 0 from the cycle after acceptance until the cycle after the rsp handshake. No request is accepted in the same cycle as the rsp handshake.
- rsp_ready held high before DONE has no effect.
- Reset mid-operation: any state returns to IDLE asynchronously and ring_reset asserts immediately. The partial result is discarded; no rsp_valid is produced.
- The ring is never released (ring_reset=0) outside SETTLE.

Test Plan:
- Reset check: reset_n=0 mid-SETTLE -> ring_reset=1, rsp_valid=0, req_ready=1 immediately; after release, first request completes normally.
- Single sample: R=4, S=10, N=1, challenge 0xA5A5_5A5A, ring_response model tied 1 -> ring_reset low exactly 10 cycles; rsp_valid after edge 14; rsp_bit=1, rsp_stable=1, rsp_ones=1.
- Majority: R=4, S=10, N=3, ring model returns 1,0,1 per evaluation -> rsp_valid after edge 42; rsp_bit=1, rsp_stable=0, rsp_ones=2; three ring_reset low pulses of 10 cycles each.
- Tie and zero-config: cfg_samples=2 with model returning 1,0 -> rsp_bit=0, rsp_ones=1. cfg_reset_cycles=0 and cfg_settle_cycles=0 -> behaves as R=1, S=1.
- Handshake backpressure: rsp_ready held 0 for 20 cycles after rsp_valid -> outputs stable, req_ready=0, req_valid ignored. rsp_ready=1 -> rsp_valid low next cycle, req_ready high.
- Challenge integrity: change req_challenge and cfg inputs every cycle while busy -> ring_challenge and timing unchanged from accepted values; ring_challenge never toggles while ring_reset=0 (assertion).
